rgbw_frame_decoder: RTL and testbench

Parametrised successor of the RGBW SPI data dispenser. Consumes the byte stream from the SPI receiver (one byte per `rx_rdy` rising edge), hunts for a sync byte, collects `NUM_CH` channel bytes plus a mode byte, and atomically publishes a complete frame to the colour/PWM pipeline. Adds an inter-byte timeout, frame status strobes and an optional checksum byte.

---
 rtl/rgbw_frame_decoder_if.sv | 23 ++
 rtl/rgbw_frame_decoder.sv | 166 ++++++++++++++++
 tb/tb_rgbw_frame_decoder.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/rgbw_frame_decoder_if.sv
// Byte-stream input and published-frame output bundle of rgbw_frame_decoder.
// The master drives the SPI byte stream. The slave is the decoder, which returns the frame.
interface rgbw_frame_decoder_if #(
    parameter int NUM_CH = 6
);
    logic [7:0]          rx_byte;
    logic                rx_rdy;
    logic [8*NUM_CH-1:0] ch_out;
    logic [7:0]          mode_out;
    logic                frame_ok;
    logic                frame_err;
    logic                busy;

    modport master (
        output rx_byte, rx_rdy,
        input  ch_out, mode_out, frame_ok, frame_err, busy
    );

    modport slave (
        input  rx_byte, rx_rdy,
        output ch_out, mode_out, frame_ok, frame_err, busy
    );
endinterface

// File: rtl/rgbw_frame_decoder.sv
// Sync-hunting RGBW frame decoder with inter-byte timeout and atomic frame publish.
// Optional trailing XOR checksum byte is enabled with the macro FRAME_CKSUM_EN.
module rgbw_frame_decoder #(
    parameter int         NUM_CH      = 6,
    parameter logic [7:0] SYNC_BYTE   = 8'h55,
    parameter int         TIMEOUT_CYC = 1000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    ce,
    rgbw_frame_decoder_if.slave     bus
);
    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH - 1);
    localparam logic [15:0]      TMO_LAST = 16'(TIMEOUT_CYC - 1);

`ifdef FRAME_CKSUM_EN
    typedef enum logic [1:0] {HUNT, PAYLOAD, MODE, CKSUM} state_t;
`else
    typedef enum logic [1:0] {HUNT, PAYLOAD, MODE} state_t;
`endif

    state_t              state_r;
    logic [IDX_W-1:0]    idx_r;
    logic [15:0]         tmo_cnt_r;
    logic [7:0]          shadow_r [NUM_CH];
    logic                rdy_s_r;
    logic                rdy_d_r;
    logic [8*NUM_CH-1:0] ch_out_r;
    logic [7:0]          mode_out_r;
    logic                frame_ok_r;
    logic                frame_err_r;
    logic                busy_r;
`ifdef FRAME_CKSUM_EN
    logic [7:0]          acc_r;
    logic [7:0]          mode_sh_r;
`endif

    logic                strobe_s;
    logic                tmo_hit_s;
    logic [8*NUM_CH-1:0] shadow_flat_s;

    // Byte strobe edge detect, timeout threshold and shadow flattening for publish.
    always_comb begin
        strobe_s      = rdy_s_r & ~rdy_d_r;
        tmo_hit_s     = (tmo_cnt_r == TMO_LAST);
        shadow_flat_s = {(8*NUM_CH){1'b0}};
        for (int i = 0; i < NUM_CH; i++) begin
            shadow_flat_s[8*i +: 8] = shadow_r[i];
        end
    end

    // Frame FSM with registered outputs; pulses clear on every clk, the rest advances on ce.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r     <= HUNT;
            idx_r       <= {IDX_W{1'b0}};
            tmo_cnt_r   <= 16'd0;
            rdy_s_r     <= 1'b0;
            rdy_d_r     <= 1'b0;
            ch_out_r    <= {(8*NUM_CH){1'b0}};
            mode_out_r  <= 8'd0;
            frame_ok_r  <= 1'b0;
            frame_err_r <= 1'b0;
            busy_r      <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                shadow_r[i] <= 8'd0;
            end
`ifdef FRAME_CKSUM_EN
            acc_r       <= 8'd0;
            mode_sh_r   <= 8'd0;
`endif
        end else begin
            frame_ok_r  <= 1'b0;
            frame_err_r <= 1'b0;
            if (ce) begin
                rdy_s_r <= bus.rx_rdy;
                rdy_d_r <= rdy_s_r;
                if ((state_r == HUNT) || strobe_s) begin
                    tmo_cnt_r <= 16'd0;
                end else begin
                    tmo_cnt_r <= tmo_cnt_r + 16'd1;
                end

                case (state_r)
                    HUNT: begin
                        if (strobe_s && (bus.rx_byte == SYNC_BYTE)) begin
                            state_r <= PAYLOAD;
                            idx_r   <= {IDX_W{1'b0}};
                            busy_r  <= 1'b1;
`ifdef FRAME_CKSUM_EN
                            acc_r   <= 8'd0;
`endif
                        end
                    end
                    PAYLOAD: begin
                        if (strobe_s) begin
                            shadow_r[idx_r] <= bus.rx_byte;
`ifdef FRAME_CKSUM_EN
                            acc_r <= acc_r ^ bus.rx_byte;
`endif
                            if (idx_r == LAST_IDX) begin
                                state_r <= MODE;
                            end else begin
                                idx_r <= idx_r + IDX_W'(1);
                            end
                        end else if (tmo_hit_s) begin
                            state_r     <= HUNT;
                            busy_r      <= 1'b0;
                            frame_err_r <= 1'b1;
                        end
                    end
                    MODE: begin
                        if (strobe_s) begin
`ifdef FRAME_CKSUM_EN
                            mode_sh_r <= bus.rx_byte;
                            acc_r     <= acc_r ^ bus.rx_byte;
                            state_r   <= CKSUM;
`else
                            ch_out_r   <= shadow_flat_s;
                            mode_out_r <= bus.rx_byte;
                            frame_ok_r <= 1'b1;
                            busy_r     <= 1'b0;
                            state_r    <= HUNT;
`endif
                        end else if (tmo_hit_s) begin
                            state_r     <= HUNT;
                            busy_r      <= 1'b0;
                            frame_err_r <= 1'b1;
                        end
                    end
`ifdef FRAME_CKSUM_EN
                    CKSUM: begin
                        if (strobe_s) begin
                            if (bus.rx_byte == acc_r) begin
                                ch_out_r   <= shadow_flat_s;
                                mode_out_r <= mode_sh_r;
                                frame_ok_r <= 1'b1;
                            end else begin
                                frame_err_r <= 1'b1;
                            end
                            busy_r  <= 1'b0;
                            state_r <= HUNT;
                        end else if (tmo_hit_s) begin
                            state_r     <= HUNT;
                            busy_r      <= 1'b0;
                            frame_err_r <= 1'b1;
                        end
                    end
`endif
                    default: begin
                        state_r <= HUNT;
                        busy_r  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.ch_out    = ch_out_r;
    assign bus.mode_out  = mode_out_r;
    assign bus.frame_ok  = frame_ok_r;
    assign bus.frame_err = frame_err_r;
    assign bus.busy      = busy_r;

endmodule

// File: tb/tb_rgbw_frame_decoder.sv
// Directed self-checking bench for rgbw_frame_decoder (NUM_CH=6, short timeout).
// Honours FRAME_CKSUM_EN by appending checksum bytes and running the checksum cases.
module tb_rgbw_frame_decoder;
    localparam int NUM_CH  = 6;
    localparam int TMO_CYC = 20;

    logic clk   = 1'b0;
    logic ce    = 1'b0;
    logic reset = 1'b0;

    int tests  = 0;
    int fails  = 0;
    int ok_cnt = 0;
    int err_cnt = 0;
    int ok0;
    int err0;

    rgbw_frame_decoder_if #(.NUM_CH(NUM_CH)) bus ();

    rgbw_frame_decoder #(
        .NUM_CH      (NUM_CH),
        .SYNC_BYTE   (8'h55),
        .TIMEOUT_CYC (TMO_CYC)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .ce    (ce),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Half-rate clock enable, changed away from the active edge.
    always @(negedge clk) ce = ~ce;

    // Pulse counters; each pulse is exactly one clk wide.
    always @(negedge clk) begin
        if (bus.frame_ok)  ok_cnt  = ok_cnt + 1;
        if (bus.frame_err) err_cnt = err_cnt + 1;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests = tests + 1;
        if (got !== exp) begin
            fails = fails + 1;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // rx_rdy high for 3 ce cycles, then low for 3 ce cycles.
    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        bus.rx_byte = b;
        bus.rx_rdy  = 1'b1;
        wait_clk(6);
        bus.rx_rdy  = 1'b0;
        wait_clk(6);
    endtask

    task automatic send_frame(input logic [47:0] chs, input logic [7:0] mode);
        logic [7:0] x;
        x = 8'h00;
        send_byte(8'h55);
        for (int i = 0; i < NUM_CH; i++) begin
            send_byte(chs[8*i +: 8]);
            x = x ^ chs[8*i +: 8];
        end
        send_byte(mode);
        x = x ^ mode;
`ifdef FRAME_CKSUM_EN
        send_byte(x);
`endif
    endtask

    initial begin
        bus.rx_byte = 8'h00;
        bus.rx_rdy  = 1'b0;

        // Reset held with ce toggling and rx_rdy wiggling.
        wait_clk(3);
        bus.rx_byte = 8'h55;
        bus.rx_rdy  = 1'b1;
        wait_clk(6);
        bus.rx_rdy  = 1'b0;
        wait_clk(4);
        check("rst_ch",   bus.ch_out, 64'd0);
        check("rst_mode", bus.mode_out, 64'd0);
        check("rst_busy", bus.busy, 64'd0);
        check("rst_ok",   bus.frame_ok, 64'd0);
        check("rst_err",  bus.frame_err, 64'd0);
        reset = 1'b1;
        wait_clk(12);
        check("rel_ok_cnt",  ok_cnt, 64'd0);
        check("rel_err_cnt", err_cnt, 64'd0);

        // Good frame.
        ok0 = ok_cnt; err0 = err_cnt;
        send_byte(8'h55);
        check("busy_after_sync", bus.busy, 64'd1);
        for (int i = 0; i < 6; i++) begin
            logic [47:0] v;
            v = 48'h20_40_80_FF_02_10;
            send_byte(v[8*i +: 8]);
        end
        check("no_publish_before_mode", ok_cnt - ok0, 64'd0);
        send_byte(8'h03);
`ifdef FRAME_CKSUM_EN
        send_byte(8'h0E);
`endif
        check("good_ch",   bus.ch_out, 64'h20_40_80_FF_02_10);
        check("good_mode", bus.mode_out, 64'h03);
        check("good_ok",   ok_cnt - ok0, 64'd1);
        check("good_err",  err_cnt - err0, 64'd0);
        check("good_busy", bus.busy, 64'd0);

        // Garbage before sync, sync value inside payload.
        ok0 = ok_cnt; err0 = err_cnt;
        send_byte(8'h00);
        send_byte(8'hAA);
        check("garbage_busy", bus.busy, 64'd0);
        send_frame(48'h77_66_44_33_55_01, 8'h9A);
        check("garb_ch",   bus.ch_out, 64'h77_66_44_33_55_01);
        check("garb_mode", bus.mode_out, 64'h9A);
        check("garb_ok",   ok_cnt - ok0, 64'd1);
        check("garb_err",  err_cnt - err0, 64'd0);

        // Timeout mid-frame.
        ok0 = ok_cnt; err0 = err_cnt;
        send_byte(8'h55);
        send_byte(8'h10);
        send_byte(8'h02);
        check("tmo_early", err_cnt - err0, 64'd0);
        for (int i = 0; i < 4 * TMO_CYC && err_cnt == err0; i++) @(negedge clk);
        wait_clk(2 * TMO_CYC);
        check("tmo_err",  err_cnt - err0, 64'd1);
        check("tmo_ok",   ok_cnt - ok0, 64'd0);
        check("tmo_busy", bus.busy, 64'd0);
        check("tmo_ch",   bus.ch_out, 64'h77_66_44_33_55_01);
        check("tmo_mode", bus.mode_out, 64'h9A);
        send_frame(48'hA1_B2_C3_D4_E5_F6, 8'h5C);
        check("post_tmo_ch", bus.ch_out, 64'hA1_B2_C3_D4_E5_F6);
        check("post_tmo_ok", ok_cnt - ok0, 64'd1);

`ifdef FRAME_CKSUM_EN
        // Checksum good then bad.
        ok0 = ok_cnt; err0 = err_cnt;
        send_byte(8'h55);
        for (int b = 1; b <= 7; b++) send_byte(8'(b));
        send_byte(8'h00);
        check("ck_ch",   bus.ch_out, 64'h06_05_04_03_02_01);
        check("ck_mode", bus.mode_out, 64'h07);
        check("ck_ok",   ok_cnt - ok0, 64'd1);
        send_byte(8'h55);
        for (int b = 1; b <= 7; b++) send_byte(8'(b + 16));
        send_byte(8'h01);
        check("ckbad_err", err_cnt - err0, 64'd1);
        check("ckbad_ok",  ok_cnt - ok0, 64'd1);
        check("ckbad_ch",  bus.ch_out, 64'h06_05_04_03_02_01);
`endif

        // Reset mid-frame.
        ok0 = ok_cnt; err0 = err_cnt;
        send_byte(8'h55);
        send_byte(8'h10);
        send_byte(8'h02);
        reset = 1'b0;
        wait_clk(4);
        reset = 1'b1;
        wait_clk(4);
        check("mid_rst_ch",   bus.ch_out, 64'd0);
        check("mid_rst_mode", bus.mode_out, 64'd0);
        check("mid_rst_busy", bus.busy, 64'd0);
        check("mid_rst_err",  err_cnt - err0, 64'd0);
        send_frame(48'h20_40_80_FF_02_10, 8'h03);
        check("rec_ch",   bus.ch_out, 64'h20_40_80_FF_02_10);
        check("rec_mode", bus.mode_out, 64'h03);
        check("rec_ok",   ok_cnt - ok0, 64'd1);
        check("rec_err",  err_cnt - err0, 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
